// File: rtl/present_pkg.sv
// Shared constants, state encoding and the inverse bit permutation for the
// PRESENT decryption round datapath.
package present_pkg;

    localparam int BLOCK_W  = 64;
    localparam int NIBBLE_W = 4;

    // Element k holds invS(k); listed MSB-first so index 0 is the rightmost entry.
    localparam logic [15:0][NIBBLE_W-1:0] INV_SBOX = {
        4'hA, 4'h9, 4'h7, 4'h0, 4'h3, 4'h6, 4'h4, 4'hB,
        4'hD, 4'h2, 4'h1, 4'hC, 4'h8, 4'hF, 4'hE, 4'h5
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result bit i takes input bit (16*i mod 63); bit 63 maps to itself.
    function automatic logic [BLOCK_W-1:0] inv_player(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int i = 0; i < BLOCK_W; i++) begin
            r[i] = x[(i == 63) ? 63 : ((16 * i) % 63)];
        end
        return r;
    endfunction

endpackage

// File: rtl/present_inv_sbox.sv
// Combinational 4-bit PRESENT inverse S-box lookup.
module present_inv_sbox
    import present_pkg::*;
(
    input  logic [NIBBLE_W-1:0] din,
    output logic [NIBBLE_W-1:0] dout
);

    assign dout = INV_SBOX[din];

endmodule

// File: rtl/present_inv_sp_round.sv
// One inverse PRESENT round body: invSLayer(invPLayer(state ^ key)), with the
// S-box layer applied NPC nibbles per cycle behind a valid/ready handshake.
module present_inv_sp_round
    import present_pkg::*;
#(
    parameter int NPC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLOCK_W-1:0]  state_in,
    input  logic [BLOCK_W-1:0]  round_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLOCK_W-1:0]  out_data
);

    localparam int NGROUPS = 16 / NPC;
    localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGROUPS - 1);

    generate
        if (!(NPC == 1 || NPC == 2 || NPC == 4 || NPC == 8 || NPC == 16)) begin : g_bad_npc
            $error("present_inv_sp_round: NPC must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BLOCK_W-1:0]  w_q, w_d;

    logic [NPC-1:0][NIBBLE_W-1:0] sb_in;
    logic [NPC-1:0][NIBBLE_W-1:0] sb_out;

    // Select the current group's nibbles from the working register.
    always_comb begin
        sb_in = '0;
        for (int j = 0; j < NPC; j++) begin
            sb_in[j] = w_q[(int'(cnt_q) * NPC + j) * NIBBLE_W +: NIBBLE_W];
        end
    end

    generate
        for (genvar j = 0; j < NPC; j++) begin : g_sbox
            present_inv_sbox u_sbox (
                .din  (sb_in[j]),
                .dout (sb_out[j])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_d     = inv_player(state_in ^ round_key);
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int j = 0; j < NPC; j++) begin
                    w_d[(int'(cnt_q) * NPC + j) * NIBBLE_W +: NIBBLE_W] = sb_out[j];
                end
                // Counter parks on the last group rather than wrapping.
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_valid ? w_q : '0;

endmodule
